// File: rtl/prince_sbox_cms_sched_pkg.sv
// Shared constants and types for the masked PRINCE S-box scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prince_cms_pkg;

    localparam int NIB      = 16;  // nibbles per share
    localparam int SHARES   = 3;   // Boolean shares
    localparam int SBOX_LAT = 2;   // S-box pipeline depth, sb_in to sb_out

    // One nibble position across every share: {s2, s1, s0}
    typedef logic [SHARES*4-1:0] nib_sh_t;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } sched_st_e;

endpackage

// File: rtl/prince_sbox_cms_sched_vpipe.sv
// Delay line of "nibble fed" flags matching the S-box pipeline depth.
// Latency: LAT cycles from fed to wb_fire.
// Backpressure: none; it shifts every cycle and clears on reset.
// Ports: clk, rst_n (async active-low), fed (a nibble enters the S-box this cycle),
//        wb_fire (the matching S-box result is on sb_out this cycle).
module prince_sched_vpipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fed,
    output logic wb_fire
);

    logic [LAT-1:0] vpipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= fed;
            for (int i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    assign wb_fire = vpipe[LAT-1];

endmodule

// File: rtl/prince_sbox_cms_sched.sv
// Streams a 3-share masked 64-bit PRINCE state through one pipelined CMS S-box, a nibble per cycle.
// Latency: out_valid is first seen by the downstream edge NIB+SBOX_LAT+1 cycles after acceptance.
// Backpressure: in_ready only in IDLE; out_state is held in DONE until out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_state input handshake;
//        out_valid/out_ready/out_state output handshake; sb_in/sb_en/sb_out S-box interface; busy.
// Build option: SBOX_ISOLATE_EN zeroes sb_in outside FEED and drops sb_en in IDLE and DONE.
module prince_sbox_cms_sched
    import prince_cms_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SHARES*4*NIB-1:0]  in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SHARES*4*NIB-1:0]  out_state,
    output logic [SHARES*4-1:0]      sb_in,
    output logic                     sb_en,
    input  logic [SHARES*4-1:0]      sb_out,
    output logic                     busy
);

    localparam int SW = 4 * NIB;        // bits per share
    localparam int CW = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    sched_st_e             st, st_nx;
    logic [SHARES*SW-1:0]  buffer;
    logic [CW-1:0]         feed_cnt;
    logic [CW-1:0]         wb_cnt;
    logic                  wb_fire;
    logic                  accept;
    nib_sh_t               cur_nib;

    assign accept = in_valid && in_ready;

    // Nibble mux: each share selects its own nibble; shares never mix.
    always_comb begin
        cur_nib = '0;
        for (int s = 0; s < SHARES; s++) begin
            cur_nib[s*4 +: 4] = buffer[s*SW + int'(feed_cnt)*4 +: 4];
        end
    end

    prince_sched_vpipe #(.LAT(SBOX_LAT)) u_vpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .fed     (st == FEED),
        .wb_fire (wb_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_nx;
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (accept) st_nx = FEED;
            FEED:    if (feed_cnt == LAST) st_nx = DRAIN;
            DRAIN:   if (wb_fire && wb_cnt == LAST) st_nx = DONE;
            DONE:    if (out_ready) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    // Counters hold at LAST instead of wrapping; write-back trails the feed by
    // the S-box depth, so the nibble being rewritten was read long ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer   <= '0;
            feed_cnt <= '0;
            wb_cnt   <= '0;
        end else if (accept) begin
            buffer   <= in_state;
            feed_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (st == FEED && feed_cnt != LAST) begin
                feed_cnt <= feed_cnt + 1'b1;
            end
            if (wb_fire) begin
                for (int s = 0; s < SHARES; s++) begin
                    buffer[s*SW + int'(wb_cnt)*4 +: 4] <= sb_out[s*4 +: 4];
                end
                if (wb_cnt != LAST) begin
                    wb_cnt <= wb_cnt + 1'b1;
                end
            end
        end
    end

    // rst_n gating keeps in_ready low while reset is applied.
    assign in_ready  = rst_n && (st == IDLE);
    assign out_valid = (st == DONE);
    assign out_state = buffer;
    assign busy      = (st == FEED) || (st == DRAIN);

`ifdef SBOX_ISOLATE_EN
    assign sb_in = (st == FEED) ? cur_nib : '0;
    assign sb_en = (st == FEED) || (st == DRAIN);
`else
    assign sb_in = cur_nib;
    assign sb_en = rst_n;
`endif

endmodule
